// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants and the stage-1 request record for the instruction encoder.
package instr_encoder_pkg;

  // Format codes shared with the core's immediate decoder (imm_src)
  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } enc_req_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder; master is the loader, slave is the encoder.
interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );

endinterface

// File: rtl/instr_encoder_imm_range_check.sv
// Immediate range/legality check: flags immediates the selected format cannot represent.
// Latency: combinational.
// Backpressure: none, pure function of fmt and imm.
module imm_range_check
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic        err
);

  logic fits_12;
  logic fits_13;
  logic fits_21;

  // A signed value fits in N bits when every bit from N-1 upward is a copy of the sign
  assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    err = 1'b1;
    case (fmt)
      FMT_I, FMT_S: err = !fits_12;
      FMT_B:        err = !fits_13 || imm[0];
      FMT_J:        err = !fits_21 || imm[0];
      FMT_U:        err = |imm[11:0];
      default:      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: range-checks the immediate and packs fields into an addressed word.
// Latency: 2 cycles from input handshake to out_valid; 1 word/cycle throughput.
// Backpressure: skid-free ready chain, in_ready = !s1_valid || !s2_valid || out_ready.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_encoder_if.slave       bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  enc_req_t    in_req;
  enc_req_t    s1_req;
  logic        in_err;
  logic        s1_valid;
  logic        s1_err;
  logic        s2_valid;
  logic        s2_err;
  logic [31:0] s2_instr;
  logic [31:0] addr_q;
  logic [31:0] packed_word;
  logic        s1_ready;
  logic        s2_ready;
  logic        in_fire;
  logic        s1_fire;
  logic        out_fire;

  assign in_req = '{
    fmt:    bus.in_fmt,
    opcode: bus.in_opcode,
    rd:     bus.in_rd,
    rs1:    bus.in_rs1,
    rs2:    bus.in_rs2,
    funct3: bus.in_funct3,
    imm:    bus.in_imm
  };

  imm_range_check u_range_check (
    .fmt (bus.in_fmt),
    .imm (bus.in_imm),
    .err (in_err)
  );

  assign s2_ready     = !s2_valid || bus.out_ready;
  assign s1_ready     = !s1_valid || s2_ready;
  assign bus.in_ready = s1_ready;

  assign in_fire  = bus.in_valid && s1_ready;
  assign s1_fire  = s1_valid && s2_ready;
  assign out_fire = s2_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_req   <= '0;
    end else begin
      if (s1_ready) s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_req <= in_req;
        s1_err <= in_err;
      end
    end
  end

  // Errored requests collapse to a NOP so the loader can stream them without a gap
  always_comb begin
    packed_word = NOP_INSTR;
    if (!s1_err) begin
      case (s1_req.fmt)
        FMT_I: packed_word = {s1_req.imm[11:0], s1_req.rs1, s1_req.funct3, s1_req.rd, s1_req.opcode};
        FMT_S: packed_word = {s1_req.imm[11:5], s1_req.rs2, s1_req.rs1, s1_req.funct3,
                              s1_req.imm[4:0], s1_req.opcode};
        FMT_B: packed_word = {s1_req.imm[12], s1_req.imm[10:5], s1_req.rs2, s1_req.rs1,
                              s1_req.funct3, s1_req.imm[4:1], s1_req.imm[11], s1_req.opcode};
        FMT_J: packed_word = {s1_req.imm[20], s1_req.imm[10:1], s1_req.imm[11],
                              s1_req.imm[19:12], s1_req.rd, s1_req.opcode};
        FMT_U: packed_word = {s1_req.imm[31:12], s1_req.rd, s1_req.opcode};
        default: packed_word = NOP_INSTR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else begin
      if (s2_ready) s2_valid <= s1_valid;
      if (s1_fire) begin
        s2_instr <= packed_word;
        s2_err   <= s1_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= BASE_ADDR;
      err_count <= '0;
    end else if (out_fire) begin
      addr_q <= addr_q + 32'd4;
      if (s2_err && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_instr;
  assign bus.out_err   = s2_err;
  assign bus.out_addr  = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-built stall/reset sequences and a randomized scoreboard.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int ECW = 8;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
    int          stamp;
    bit          lat_chk;
  } sb_t;

  logic clk;
  logic rst_n;
  logic [ECW-1:0] err_count;

  instr_encoder_if bus ();

  instr_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(ECW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests;
  int    fails;
  int    cyc;
  sb_t   sb[$];
  vec_t  cur;
  bit    cur_lat;
  bit    last_in_fire;
  bit    stall_chk;
  logic [31:0] exp_addr;
  int    exp_errs;
  vec_t  vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: legality from the integer ranges each format can hold, packing from the field layout
  function automatic logic [32:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [2:0] f3,
                                             input logic [31:0] imm);
    int s;
    bit ok;
    logic [31:0] w;
    s = int'(signed'(imm));
    case (fmt)
      3'd0, 3'd1: ok = (s >= -2048) && (s <= 2047);
      3'd2:       ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      3'd3:       ok = (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
      3'd4:       ok = (imm % 32'd4096) == 0;
      default:    ok = 1'b0;
    endcase
    w = 32'h0000_0013;
    if (ok) begin
      case (fmt)
        3'd0: w = {imm[11:0], rs1, f3, rd, op};
        3'd1: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        3'd2: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        3'd3: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        default: w = {imm[31:12], rd, op};
      endcase
    end
    return {!ok, w};
  endfunction

  // The core's immediate decode, used to confirm encoded words round-trip
  function automatic logic [31:0] dec_imm(input logic [2:0] fmt, input logic [31:0] w);
    case (fmt)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {w[31:12], 12'b0};
    endcase
  endfunction

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.imm = imm;
    v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [32:0] r;
    v.fmt = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
    v.op  = 7'($urandom);
    v.rd  = 5'($urandom);
    v.rs1 = 5'($urandom);
    v.rs2 = 5'($urandom);
    v.f3  = 3'($urandom);
    case ($urandom_range(0, 3))
      0: v.imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      1: v.imm = 32'($urandom_range(0, 4 << 20)) - 32'(2 << 20);
      2: v.imm = $urandom & 32'hFFFF_F000;
      default: v.imm = $urandom;
    endcase
    r = ref_encode(v.fmt, v.op, v.rd, v.rs1, v.rs2, v.f3, v.imm);
    v.exp_err   = r[32];
    v.exp_instr = r[31:0];
    return v;
  endfunction

  task automatic set_in(input vec_t v);
    bus.in_fmt    = v.fmt;
    bus.in_opcode = v.op;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_funct3 = v.f3;
    bus.in_imm    = v.imm;
    cur = v;
  endtask

  // One clock: observe handshakes just before the edge, then advance to the next falling edge
  task automatic step();
    sb_t e;
    bit  in_fire;
    bit  out_fire;
    #1;
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    if (stall_chk && bus.out_valid && !bus.out_ready && sb.size() > 0) begin
      chk("stall_instr", bus.out_instr, sb[0].instr);
      chk("stall_addr", bus.out_addr, exp_addr);
    end
    if (out_fire) begin
      if (sb.size() == 0) begin
        chk("spurious_out", bus.out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("out_instr", bus.out_instr, e.instr);
        chk("out_err", bus.out_err, e.err);
        chk("out_addr", bus.out_addr, exp_addr);
        chk("err_count", err_count, exp_errs);
        if (e.lat_chk) chk("latency", cyc - e.stamp, 2);
        if (!e.err) chk("round_trip", dec_imm(e.fmt, bus.out_instr), e.imm);
        exp_addr = exp_addr + 32'd4;
        if (e.err && exp_errs < (1 << ECW) - 1) exp_errs++;
      end
    end
    if (in_fire) begin
      e.instr = cur.exp_instr; e.err = cur.exp_err; e.fmt = cur.fmt; e.imm = cur.imm;
      e.stamp = cyc; e.lat_chk = cur_lat;
      sb.push_back(e);
    end
    last_in_fire = in_fire;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input vec_t v, input bit lat);
    set_in(v);
    cur_lat = lat;
    bus.in_valid = 1'b1;
    last_in_fire = 1'b0;
    for (int k = 0; k < 40 && !last_in_fire; k++) step();
    if (!last_in_fire) chk("in_accept_timeout", last_in_fire, 1'b1);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60 && sb.size() > 0; k++) step();
    chk("drain_left", sb.size(), 0);
    step();
    chk("no_extra_out", bus.out_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_addr = BASE;
    exp_errs = 0;
  endtask

  initial begin
    int acc;
    vec_t bp[4];
    tests = 0; fails = 0; cyc = 0; stall_chk = 1'b0; cur_lat = 1'b0; last_in_fire = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_fmt = '0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_imm = '0;

    vecs[0]  = mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5,          32'h0050_0093, 1'b0);
    vecs[1]  = mk(3'd1, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, -32'sd4,        32'hFE21_AE23, 1'b0);
    vecs[2]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
    vecs[3]  = mk(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8,          32'h0080_00EF, 1'b0);
    vecs[4]  = mk(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd1,          32'h0000_0013, 1'b1);
    vecs[5]  = mk(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2047,       32'h7FF0_0013, 1'b0);
    vecs[6]  = mk(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd2048,     32'h8000_0013, 1'b0);
    vecs[7]  = mk(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2048,       32'h0000_0013, 1'b1);
    vecs[8]  = mk(3'd7, 7'h13, 5'd3, 5'd4, 5'd5, 3'd1, 32'd0,          32'h0000_0013, 1'b1);
    vecs[9]  = mk(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8,        32'hFE20_8CE3, 1'b0);
    vecs[10] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001,  32'h0000_0013, 1'b1);
    vecs[11] = mk(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0000,  32'h0000_0013, 1'b1);

    @(negedge clk);
    do_reset();
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_addr", bus.out_addr, BASE);
    chk("rst_err_count", err_count, 0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_err", bus.out_err, 1'b0);
    @(negedge clk);

    // Directed table: S then U go out back-to-back, B with odd offset bumps the error count
    bus.out_ready = 1'b1;
    send(vecs[0], 1'b1);
    bus.in_valid = 1'b0;
    drain();
    for (int i = 1; i < 12; i++) send(vecs[i], 1'b1);
    drain();
    chk("err_count_directed", err_count, exp_errs);

    // Backpressure: only two words fit while the consumer stalls
    do_reset();
    for (int i = 0; i < 4; i++) bp[i] = rand_vec();
    bus.out_ready = 1'b0;
    stall_chk = 1'b1;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      set_in(bp[acc]);
      cur_lat = 1'b0;
      bus.in_valid = 1'b1;
      step();
      if (last_in_fire) acc++;
    end
    chk("bp_accepted", acc, 2);
    #1;
    chk("bp_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    while (acc < 4) begin
      send(bp[acc], 1'b0);
      acc++;
    end
    drain();
    chk("bp_final_addr", bus.out_addr, BASE + 32'd16);

    // Randomized traffic with random stalls and valid dropouts
    for (int k = 0; k < 500; k++) begin
      if (!bus.in_valid || last_in_fire) begin
        set_in(rand_vec());
        cur_lat = 1'b0;
      end
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();
    stall_chk = 1'b0;

    // Error counter saturation
    bus.out_ready = 1'b1;
    for (int k = 0; k < 260; k++) send(mk(3'd5, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h13, 1'b1), 1'b0);
    drain();
    chk("err_count_sat", err_count, 8'hFF);

    // Reset with both stages holding data
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) send(rand_vec(), 1'b0);
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_full", bus.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_addr", bus.out_addr, BASE);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_addr = BASE;
    exp_errs = 0;
    bus.out_ready = 1'b1;
    send(vecs[3], 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
